dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 105 ++++++++++
 tb/tb_dmem_responder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data memory slave with byte/half/word stores; define DMEM_ALIGN_CHECK_EN to flag misaligned or illegal-size accesses
module dmem_responder #(
  parameter int MEM_SIZE    = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int XLEN        = 32
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [1:0]      req_size_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o
);
  localparam int AW = $clog2(MEM_SIZE);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic l_we, a_we;
  logic [XLEN-1:0] l_addr, l_wdata, a_addr, a_wdata;
  logic [1:0] l_size, a_size;
  logic accept, last, access, a_err;
  logic [3:0] be;
  logic [31:0] wd;
  logic [AW-1:0] idx;
  logic [31:0] mem [MEM_SIZE];
  logic unused_addr;
  // handshake and commit point; reset blocks a commit on the same edge
  always_comb begin
    accept = req_valid_i && req_ready_o;
    last = (state == S_WAIT) && (cnt == 4'(WAIT_CYCLES - 1));
    access = rstn_i && ((WAIT_CYCLES == 0) ? accept : last);
  end
  // with zero wait states the access happens on the accept edge, so use the live request
  always_comb begin
    a_we = (state == S_IDLE) ? req_we_i : l_we;
    a_addr = (state == S_IDLE) ? req_addr_i : l_addr;
    a_size = (state == S_IDLE) ? req_size_i : l_size;
    a_wdata = (state == S_IDLE) ? req_wdata_i : l_wdata;
  end
  // word index, lane enables, lane-replicated store data and alignment error
  always_comb begin
    idx = a_addr[AW+1:2];
    be = (a_size == 2'b00) ? 4'b0001 << a_addr[1:0] : (a_size == 2'b01) ? (a_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd = (a_size == 2'b00) ? {4{a_wdata[7:0]}} : (a_size == 2'b01) ? {2{a_wdata[15:0]}} : a_wdata[31:0];
`ifdef DMEM_ALIGN_CHECK_EN
    a_err = (a_size == 2'b11) || (a_size == 2'b01 && a_addr[0]) || (a_size == 2'b10 && a_addr[1:0] != 2'b00);
`else
    a_err = 1'b0;
`endif
  end
  assign unused_addr = ^a_addr[XLEN-1:AW+2];
  // state register and wait-state counter
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state <= S_IDLE;
      cnt <= 4'd0;
    end else begin
      state <= state_n;
      cnt <= (state == S_WAIT) ? cnt + 4'd1 : 4'd0;
    end
  end
  // next-state logic
  always_comb begin
    state_n = state;
    if (state == S_IDLE) state_n = req_valid_i ? ((WAIT_CYCLES == 0) ? S_RESP : S_WAIT) : S_IDLE;
    else if (state == S_WAIT) state_n = last ? S_RESP : S_WAIT;
    else state_n = rsp_ready_i ? S_IDLE : S_RESP;
  end
  // handshake outputs; ready is held low while reset is asserted
  always_comb begin
    req_ready_o = rstn_i && (state == S_IDLE);
    rsp_valid_o = (state == S_RESP);
  end
  // capture the request on accept
  always_ff @(posedge clk_i) begin
    if (accept) begin
      l_we <= req_we_i;
      l_addr <= req_addr_i;
      l_size <= req_size_i;
      l_wdata <= req_wdata_i;
    end
  end
  // response payload, loaded only at the access edge so it holds through RESP
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rsp_rdata_o <= '0;
      rsp_err_o <= 1'b0;
    end else if (access) begin
      rsp_err_o <= a_err;
      rsp_rdata_o <= (a_we || a_err) ? '0 : mem[idx];
    end
  end
  // memory array, intentionally not reset
  always_ff @(posedge clk_i) begin
    if (access && a_we && !a_err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of latency, lanes, backpressure, reset abort, alignment and wrap
module tb_dmem_responder;
  logic clk = 0, rstn = 0, req_valid = 0, req_we = 0, rsp_ready = 1;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [1:0] req_size = 0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  int passed = 0, total = 0;
  int lat;
  logic [31:0] rd;
  logic er;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk_i(clk), .rstn_i(rstn),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  // one full transaction; lat counts edges from the accept edge to rsp_valid seen
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1; req_we = we; req_addr = addr; req_size = size; req_wdata = wd; rsp_ready = 1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      req_valid = 0;
      lat++;
    end while (!rsp_valid && lat < 20);
    rd = rsp_rdata; er = rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rstn = 0;
    @(posedge clk); #1;
    if (rsp_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", rsp_valid); else passed++; total++;
    if (rsp_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", rsp_rdata); else passed++; total++;
    if (rsp_err !== 1'b0) $display("FAIL rst_err: got %b want 0", rsp_err); else passed++; total++;
    if (req_ready !== 1'b0) $display("FAIL rst_ready_in_reset: got %b want 0", req_ready); else passed++; total++;
    @(negedge clk); rstn = 1; #1;
    if (req_ready !== 1'b1) $display("FAIL rst_ready_after: got %b want 1", req_ready); else passed++; total++;
  endtask

  task automatic test_store_load;
    xfer(1, 32'h10, 2'b10, 32'hDEADBEEF);
    if (lat !== 3) $display("FAIL store_latency: got %0d want 3", lat); else passed++; total++;
    if (rd !== 32'h0) $display("FAIL store_rdata: got %h want 0", rd); else passed++; total++;
    xfer(0, 32'h10, 2'b10, 32'h0);
    if (lat !== 3) $display("FAIL load_latency: got %0d want 3", lat); else passed++; total++;
    if (rd !== 32'hDEADBEEF) $display("FAIL load_word: got %h want deadbeef", rd); else passed++; total++;
    if (er !== 1'b0) $display("FAIL load_err: got %b want 0", er); else passed++; total++;
  endtask

  task automatic test_lanes;
    xfer(1, 32'h20, 2'b10, 32'h0);
    xfer(1, 32'h22, 2'b00, 32'hFFFF_FFAB);
    xfer(1, 32'h20, 2'b01, 32'hFFFF_1234);
    xfer(0, 32'h20, 2'b10, 32'h0);
    if (rd !== 32'h00AB1234) $display("FAIL lanes_byte_half: got %h want 00ab1234", rd); else passed++; total++;
    xfer(1, 32'h24, 2'b10, 32'hFFFFFFFF);
    xfer(1, 32'h26, 2'b01, 32'h0000_5678);
    xfer(0, 32'h24, 2'b10, 32'h0);
    if (rd !== 32'h5678FFFF) $display("FAIL lanes_upper_half: got %h want 5678ffff", rd); else passed++; total++;
    xfer(1, 32'h27, 2'b00, 32'h0000_005A);
    xfer(0, 32'h24, 2'b10, 32'h0);
    if (rd !== 32'h5A78FFFF) $display("FAIL lanes_top_byte: got %h want 5a78ffff", rd); else passed++; total++;
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    req_valid = 1; req_we = 0; req_addr = 32'h10; req_size = 2'b10; rsp_ready = 0;
    @(posedge clk); #1;
    req_we = 1; req_addr = 32'h30; req_wdata = 32'h11111111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) $display("FAIL bp_first: got valid=%b rdata=%h want 1 deadbeef", rsp_valid, rsp_rdata); else passed++; total++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0)
        $display("FAIL bp_hold%0d: got valid=%b rdata=%h ready=%b want 1 deadbeef 0", i, rsp_valid, rsp_rdata, req_ready);
      else passed++;
      total++;
    end
    @(negedge clk); rsp_ready = 1;
    @(posedge clk); #1;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL bp_handshake: got valid=%b ready=%b want 0 1", rsp_valid, req_ready); else passed++; total++;
    @(posedge clk); #1;
    if (req_ready !== 1'b0) $display("FAIL bp_next_accept: got ready=%b want 0", req_ready); else passed++; total++;
    req_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) $display("FAIL bp_next_rsp: got valid=%b rdata=%h want 1 0", rsp_valid, rsp_rdata); else passed++; total++;
    @(posedge clk); #1;
    xfer(0, 32'h30, 2'b10, 32'h0);
    if (rd !== 32'h11111111) $display("FAIL bp_store_landed: got %h want 11111111", rd); else passed++; total++;
  endtask

  task automatic test_reset_wait;
    xfer(1, 32'h0, 2'b10, 32'h12345678);
    xfer(0, 32'h0, 2'b10, 32'h0);
    if (rd !== 32'h12345678) $display("FAIL rw_prior: got %h want 12345678", rd); else passed++; total++;
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = 32'h0; req_size = 2'b10; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    @(negedge clk); rstn = 0;
    @(posedge clk); #1;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0)
      $display("FAIL rw_outputs: got valid=%b rdata=%h err=%b want 0 0 0", rsp_valid, rsp_rdata, rsp_err);
    else passed++;
    total++;
    @(negedge clk); rstn = 1;
    repeat (4) @(posedge clk);
    #1;
    if (rsp_valid !== 1'b0) $display("FAIL rw_no_rsp: got %b want 0", rsp_valid); else passed++; total++;
    xfer(0, 32'h0, 2'b10, 32'h0);
    if (rd !== 32'h12345678) $display("FAIL rw_not_written: got %h want 12345678", rd); else passed++; total++;
  endtask

  task automatic test_align;
`ifdef DMEM_ALIGN_CHECK_EN
    xfer(1, 32'h21, 2'b10, 32'h99);
    if (er !== 1'b1 || rd !== 32'h0) $display("FAIL al_word_err: got err=%b rdata=%h want 1 0", er, rd); else passed++; total++;
    if (lat !== 3) $display("FAIL al_latency: got %0d want 3", lat); else passed++; total++;
    xfer(0, 32'h20, 2'b11, 32'h0);
    if (er !== 1'b1 || rd !== 32'h0) $display("FAIL al_size11: got err=%b rdata=%h want 1 0", er, rd); else passed++; total++;
    xfer(1, 32'h21, 2'b01, 32'h7777);
    if (er !== 1'b1) $display("FAIL al_half_err: got %b want 1", er); else passed++; total++;
    xfer(0, 32'h20, 2'b10, 32'h0);
    if (er !== 1'b0 || rd !== 32'h00AB1234) $display("FAIL al_unchanged: got err=%b rdata=%h want 0 00ab1234", er, rd); else passed++; total++;
    xfer(1, 32'h21, 2'b00, 32'hEE);
    if (er !== 1'b0) $display("FAIL al_byte_ok: got %b want 0", er); else passed++; total++;
    xfer(0, 32'h20, 2'b10, 32'h0);
    if (rd !== 32'h00ABEE34) $display("FAIL al_byte_lane: got %h want 00abee34", rd); else passed++; total++;
`else
    xfer(1, 32'h21, 2'b10, 32'h99);
    if (er !== 1'b0 || rd !== 32'h0) $display("FAIL na_word_store: got err=%b rdata=%h want 0 0", er, rd); else passed++; total++;
    xfer(0, 32'h20, 2'b10, 32'h0);
    if (rd !== 32'h00000099) $display("FAIL na_word_landed: got %h want 00000099", rd); else passed++; total++;
    xfer(0, 32'h20, 2'b11, 32'h0);
    if (er !== 1'b0 || rd !== 32'h00000099) $display("FAIL na_size11: got err=%b rdata=%h want 0 00000099", er, rd); else passed++; total++;
    xfer(1, 32'h21, 2'b01, 32'h7777);
    xfer(0, 32'h20, 2'b10, 32'h0);
    if (rd !== 32'h00007777) $display("FAIL na_half_low: got %h want 00007777", rd); else passed++; total++;
`endif
  endtask

  task automatic test_wrap;
    xfer(0, 32'h1010, 2'b10, 32'h0);
    if (rd !== 32'hDEADBEEF) $display("FAIL wrap_load: got %h want deadbeef", rd); else passed++; total++;
    xfer(1, 32'h80001014, 2'b10, 32'hA5A5A5A5);
    xfer(0, 32'h14, 2'b10, 32'h0);
    if (rd !== 32'hA5A5A5A5) $display("FAIL wrap_store: got %h want a5a5a5a5", rd); else passed++; total++;
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_lanes;
    test_backpressure;
    test_reset_wait;
    test_align;
    test_wrap;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
